// File: rtl/ss_modport.sv
// rtl/ss_modport.sv - Forth data-stack engine with registered tos and cached second element s0
package ss_modport_pkg;
    typedef enum logic [1:0] {
        SS_LOAD = 2'd0,
        SS_PUSH = 2'd1,
        SS_POP  = 2'd2,
        SS_PICK = 2'd3
    } sop_e;
endpackage

module ss_modport
    import ss_modport_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int DSZ   = 32,
    localparam int SSZ  = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  sop_e           op,
    input  logic [DSZ-1:0] vi,
    output logic [DSZ-1:0] tos,
    output logic [DSZ-1:0] s0,
    output logic [SSZ-1:0] sp
);

    logic [DSZ-1:0] mem [DEPTH];

    logic [SSZ-1:0] sp_inc;
    logic [SSZ-1:0] sp_dec;
    logic [SSZ-1:0] pick_idx;

    // All index arithmetic wraps naturally at SSZ bits, so over/underflow needs no special case
    always_comb begin
        sp_inc   = sp + 1'b1;
        sp_dec   = sp - 1'b1;
        pick_idx = sp - vi[SSZ-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tos <= '1;
            s0  <= '0;
            sp  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            case (op)
                SS_LOAD: begin
                    tos <= vi;
                end
                SS_PUSH: begin
                    mem[sp_inc] <= tos;
                    s0          <= tos;
                    sp          <= sp_inc;
                    tos         <= vi;
                end
                // s0 is refilled from the cell below so the next POP stays latency-free
                SS_POP: begin
                    tos <= s0;
                    sp  <= sp_dec;
                    s0  <= mem[sp_dec];
                end
                SS_PICK: begin
                    tos <= mem[pick_idx];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ss_modport.sv
// tb/tb_ss_modport.sv - self-checking bench for ss_modport against a circular-stack model
module tb_ss_modport;
    import ss_modport_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    sop_e        op  = SS_LOAD;
    logic [31:0] vi  = '0;
    logic [31:0] tos;
    logic [31:0] s0;
    logic [5:0]  sp;

    int tests = 0;
    int fails = 0;

    // Reference: a circular array of 64 cells plus a top-of-stack value
    logic [31:0] m_mem [64];
    logic [31:0] m_tos;
    int          m_sp;

    ss_modport dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .op  (op),
        .vi  (vi),
        .tos (tos),
        .s0  (s0),
        .sp  (sp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_tos = 32'hFFFF_FFFF;
        m_sp  = 0;
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
    endtask

    task automatic model_exec(input logic e, input int o, input logic [31:0] v);
        if (!e) return;
        case (o)
            0: m_tos = v;
            1: begin
                m_sp        = (m_sp + 1) % 64;
                m_mem[m_sp] = m_tos;
                m_tos       = v;
            end
            2: begin
                m_tos = m_mem[m_sp];
                m_sp  = (m_sp + 63) % 64;
            end
            default: m_tos = m_mem[(m_sp - int'(v[5:0]) + 64) % 64];
        endcase
    endtask

    task automatic step(input logic e, input int o, input logic [31:0] v);
        @(negedge clk);
        en = e;
        op = sop_e'(o[1:0]);
        vi = v;
        @(posedge clk);
        #1;
        model_exec(e, o, v);
    endtask

    task automatic chk_model(input string name);
        chk({name, ".tos"}, tos, m_tos);
        chk({name, ".s0"}, s0, m_mem[m_sp]);
        chk({name, ".sp"}, {26'd0, sp}, 32'(m_sp));
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst.tos", tos, 32'hFFFF_FFFF);
        chk("rst.s0", s0, 32'd0);
        chk("rst.sp", {26'd0, sp}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        step(1'b1, 1, 32'd5);
        chk("push5.tos", tos, 32'd5);
        chk("push5.s0", s0, 32'hFFFF_FFFF);
        chk("push5.sp", {26'd0, sp}, 32'd1);
        step(1'b1, 1, 32'd7);
        chk("push7.tos", tos, 32'd7);
        chk("push7.s0", s0, 32'd5);
        chk("push7.sp", {26'd0, sp}, 32'd2);
        step(1'b1, 1, 32'd9);
        chk("push9.tos", tos, 32'd9);
        chk("push9.s0", s0, 32'd7);
        chk("push9.sp", {26'd0, sp}, 32'd3);

        chk("pop1.pre_s0", s0, 32'd7);
        step(1'b1, 2, 32'd0);
        chk("pop1.tos", tos, 32'd7);
        chk("pop1.s0", s0, 32'd5);
        chk("pop1.sp", {26'd0, sp}, 32'd2);
        chk("pop2.pre_s0", s0, 32'd5);
        step(1'b1, 2, 32'd0);
        chk("pop2.tos", tos, 32'd5);
        chk("pop2.s0", s0, 32'hFFFF_FFFF);
        chk("pop2.sp", {26'd0, sp}, 32'd1);

        step(1'b1, 1, 32'd7);
        step(1'b1, 1, 32'd9);
        step(1'b1, 0, 32'd42);
        chk("load.tos", tos, 32'd42);
        chk("load.s0", s0, 32'd7);
        chk("load.sp", {26'd0, sp}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1, 32'd99);
            chk_model("idle");
        end
        chk("idle.tos", tos, 32'd42);

        step(1'b1, 0, 32'd9);
        step(1'b1, 3, 32'd1);
        chk("pick1.tos", tos, 32'd5);
        chk("pick1.sp", {26'd0, sp}, 32'd3);
        step(1'b1, 3, 32'd0);
        chk("pick0.tos", tos, 32'd7);
        chk("pick0.sp", {26'd0, sp}, 32'd3);

        // Asynchronous reset landing between clock edges
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.tos", tos, 32'hFFFF_FFFF);
        chk("arst.s0", s0, 32'd0);
        chk("arst.sp", {26'd0, sp}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 1; i <= 64; i++) step(1'b1, 1, 32'(i));
        chk("wrap.sp", {26'd0, sp}, 32'd0);
        chk("wrap.tos", tos, 32'd64);
        chk("wrap.mem0", dut.mem[0], 32'd63);
        chk("wrap.s0", s0, 32'd63);
        step(1'b1, 2, 32'd0);
        chk("unwrap.tos", tos, 32'd63);
        chk("unwrap.sp", {26'd0, sp}, 32'd63);
        chk("unwrap.s0", s0, 32'd62);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), $urandom);
            chk_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
